dmem_ctrl: RTL and testbench

//  Parametrised data-memory subsystem for the next-gen CPU top: replaces the

---
 rtl/dmem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: request/response port in front of a word-organised RAM,
// with configurable wait states, byte/half/word MemOp access and misalignment detection.
module dmem_ctrl #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int NB = DW / 8;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b101;
  localparam logic [2:0] OP_HU = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          lat_we;
  logic [2:0]    lat_op;
  logic [IW+1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic          accept;
  logic          req_err;
  logic          access;
  logic          a_we;
  logic [2:0]    a_op;
  logic [IW+1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic [IW-1:0] a_idx;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_word, ld_val, wr_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [4:0]    bsh, hsh;
  logic [NB-1:0] be;

  logic          unused_addr_hi;
  assign unused_addr_hi = ^req_addr[AW-1:IW+2];

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);
  assign accept     = req_valid && (state == S_IDLE);

  always_comb begin
    req_err = 1'b0;
    case (req_op)
      OP_W:         req_err = (req_addr[1:0] != 2'b00);
      OP_H, OP_HU:  req_err = req_addr[0];
      OP_B, OP_BU:  req_err = 1'b0;
      default:      req_err = 1'b1;
    endcase
  end

  // With zero wait states the RAM is accessed on the accept edge itself,
  // so the access path takes the live request instead of the latched copy.
  assign a_we    = (state == S_IDLE) ? req_we               : lat_we;
  assign a_op    = (state == S_IDLE) ? req_op               : lat_op;
  assign a_addr  = (state == S_IDLE) ? req_addr[IW+1:0]     : lat_addr;
  assign a_wdata = (state == S_IDLE) ? req_wdata            : lat_wdata;
  assign a_idx   = a_addr[IW+1:2];

  assign access = (state == S_IDLE) ? (accept && !req_err && (WAIT_CYCLES == 0))
                                    : ((state == S_WAIT) && (cnt == '0));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err || (WAIT_CYCLES == 0)) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nx = S_RESP;
        else           cnt_nx   = cnt - 4'd1;
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign rd_word = mem[a_idx];
  assign bsh     = {a_addr[1:0], 3'b000};
  assign hsh     = {a_addr[1], 4'b0000};
  assign rd_byte = 8'(rd_word >> bsh);
  assign rd_half = 16'(rd_word >> hsh);

  always_comb begin
    ld_val  = '0;
    wr_word = '0;
    be      = '0;
    case (a_op)
      OP_W: begin
        ld_val  = rd_word;
        wr_word = a_wdata;
        be      = '1;
      end
      OP_B, OP_BU: begin
        ld_val  = (a_op == OP_B) ? {{(DW-8){rd_byte[7]}}, rd_byte} : {{(DW-8){1'b0}}, rd_byte};
        wr_word = DW'(a_wdata[7:0]) << bsh;
        be      = NB'(1) << a_addr[1:0];
      end
      OP_H, OP_HU: begin
        ld_val  = (a_op == OP_H) ? {{(DW-16){rd_half[15]}}, rd_half} : {{(DW-16){1'b0}}, rd_half};
        wr_word = DW'(a_wdata[15:0]) << hsh;
        be      = NB'(3) << {a_addr[1], 1'b0};
      end
      default: begin
        ld_val = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && access && a_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[a_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_op     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_op    <= req_op;
        lat_addr  <= req_addr[IW+1:0];
        lat_wdata <= req_wdata;
      end
      if (accept && req_err) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end else if (access) begin
        resp_err   <= 1'b0;
        resp_rdata <= a_we ? '0 : ld_val;
      end else if (state == S_RESP) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (WAIT=2/DEPTH=1024 and WAIT=0/DEPTH=16) checked
// every cycle against a byte-level memory model, plus directed literal expectations.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rv   [2];
  logic        rr   [2];
  logic        rwe  [2];
  logic [2:0]  rop  [2];
  logic [31:0] radr [2];
  logic [31:0] rwd  [2];
  logic        vld  [2];
  logic [31:0] rdat [2];
  logic        rerr [2];
  logic        bsy  [2];

  dmem_ctrl #(.DW(32), .AW(32), .DEPTH(1024), .WAIT_CYCLES(2)) u_big (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(rwe[0]),
    .req_op(rop[0]), .req_addr(radr[0]), .req_wdata(rwd[0]), .resp_valid(vld[0]),
    .resp_rdata(rdat[0]), .resp_err(rerr[0]), .busy(bsy[0])
  );

  dmem_ctrl #(.DW(32), .AW(32), .DEPTH(16), .WAIT_CYCLES(0)) u_small (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(rwe[1]),
    .req_op(rop[1]), .req_addr(radr[1]), .req_wdata(rwd[1]), .resp_valid(vld[1]),
    .resp_rdata(rdat[1]), .resp_err(rerr[1]), .busy(bsy[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_on   = 1'b0;
  int nresp [2] = '{0, 0};

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @cyc %0d: got %h expected %h", nm, inst, cyc, act, exp);
    end
  endtask

  function automatic int wait_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(int i);
    return (i == 0) ? 1024 : 16;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mm [2][1024];

  function automatic int widx(int i, logic [31:0] a);
    return int'((a / 4) % 32'(depth_of(i)));
  endfunction

  function automatic bit is_err(logic [2:0] op, logic [31:0] a);
    case (op)
      3'b000:         return (a % 4) != 0;
      3'b001, 3'b101: return 1'b0;
      3'b010, 3'b110: return (a % 2) != 0;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ld(logic [31:0] w, logic [2:0] op, logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      3'b000:  return w;
      3'b001:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b101:  return b;
      3'b010:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b110:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] st(logic [31:0] w, logic [2:0] op, logic [31:0] a, logic [31:0] d);
    logic [31:0] m, sh;
    case (op)
      3'b000: return d;
      3'b001, 3'b101: begin
        sh = 8 * (a % 4);
        m  = 32'hFF << sh;
        return (w & ~m) | ((d & 32'hFF) << sh);
      end
      3'b010, 3'b110: begin
        sh = 16 * ((a / 2) % 2);
        m  = 32'hFFFF << sh;
        return (w & ~m) | ((d & 32'hFFFF) << sh);
      end
      default: return w;
    endcase
  endfunction

  bit          pend  [2];
  int          due   [2];
  logic [31:0] e_rd  [2];
  bit          e_err [2];
  bit          e_st  [2];
  logic [2:0]  p_op  [2];
  logic [31:0] p_adr [2];
  logic [31:0] p_wd  [2];
  bit          mon_ev;
  bit          mon_busy;

  // One outstanding request per instance: expected response is fixed at accept,
  // stores land in the model only when their response is due (reset drops them).
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (vld[i] === 1'b1) nresp[i] = nresp[i] + 1;
      if (mon_on) begin
        mon_busy = pend[i];
        mon_ev   = pend[i] && (cyc == due[i]);
        chk("resp_valid", i, 32'(vld[i]), 32'(mon_ev));
        chk("req_ready",  i, 32'(rr[i]),  32'(!mon_busy));
        chk("busy",       i, 32'(bsy[i]), 32'(mon_busy));
        if (mon_ev) begin
          chk("resp_rdata", i, rdat[i], e_rd[i]);
          chk("resp_err",   i, 32'(rerr[i]), 32'(e_err[i]));
          if (e_st[i] && !e_err[i])
            mm[i][widx(i, p_adr[i])] = st(mm[i][widx(i, p_adr[i])], p_op[i], p_adr[i], p_wd[i]);
          pend[i] = 1'b0;
        end
        if (rst) begin
          pend[i] = 1'b0;
        end else if (!mon_busy && rv[i] === 1'b1) begin
          p_op[i]  = rop[i];
          p_adr[i] = radr[i];
          p_wd[i]  = rwd[i];
          e_st[i]  = rwe[i];
          e_err[i] = is_err(rop[i], radr[i]);
          e_rd[i]  = (rwe[i] || e_err[i]) ? 32'h0 : ld(mm[i][widx(i, radr[i])], rop[i], radr[i]);
          due[i]   = cyc + (e_err[i] ? 1 : wait_of(i) + 1);
          pend[i]  = 1'b1;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input int i, input bit we, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    rv[i] = 1'b1; rwe[i] = we; rop[i] = op; radr[i] = a; rwd[i] = d;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (rr[i] === 1'b1) begin
        got = 1'b1;
        @(posedge clk);
        #1;
        at = cyc;
      end
    end
    if (!got) begin
      chk("accept_timeout", i, 0, 1);
      rv[i] = 1'b0;
    end
  endtask

  task automatic txn(input int i, input bit we, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
    int at;
    bit got;
    issue(i, we, op, a, d, at);
    rv[i] = 1'b0;
    got = 1'b0;
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    if (at >= 0) begin
      for (int k = 1; k <= 40 && !got; k++) begin
        @(negedge clk);
        if (vld[i] === 1'b1) begin
          got = 1'b1;
          lat = k;
          rd  = rdat[i];
          er  = rerr[i];
        end
      end
      if (!got) chk("resp_timeout", i, 0, 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          at;
    int          g;
    int          n0;
    int          acc [6];

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rwe[i] = 1'b0; rop[i] = 3'b000; radr[i] = '0; rwd[i] = '0;
    end
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_rdata", i, rdat[i], 32'h0);
      chk("reset_err",   i, 32'(rerr[i]), 32'h0);
      chk("reset_ready", i, 32'(rr[i]), 32'h1);
      chk("reset_busy",  i, 32'(bsy[i]), 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // word store/load with wait states
    txn(0, 1'b1, 3'b000, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("sw_latency", 0, lat, 3);
    chk("sw_rdata", 0, rd, 32'h0);
    txn(0, 1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat);
    chk("lw_latency", 0, lat, 3);
    chk("lw_rdata", 0, rd, 32'hDEADBEEF);
    chk("lw_err", 0, 32'(er), 32'h0);

    // sub-word access
    txn(0, 1'b1, 3'b001, 32'h11, 32'h0000007F, rd, er, lat);
    txn(0, 1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat);
    chk("sb_merge", 0, rd, 32'hDEAD7FEF);
    txn(0, 1'b0, 3'b001, 32'h13, 32'h0, rd, er, lat);
    chk("lb_sext", 0, rd, 32'hFFFFFFDE);
    txn(0, 1'b0, 3'b101, 32'h13, 32'h0, rd, er, lat);
    chk("lbu_zext", 0, rd, 32'h000000DE);
    txn(0, 1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat);
    chk("lh_sext", 0, rd, 32'hFFFFDEAD);

    // misaligned / illegal
    txn(0, 1'b0, 3'b000, 32'h12, 32'h0, rd, er, lat);
    chk("lw_mis_err", 0, 32'(er), 32'h1);
    chk("lw_mis_lat", 0, lat, 1);
    chk("lw_mis_rdata", 0, rd, 32'h0);
    txn(0, 1'b0, 3'b010, 32'h13, 32'h0, rd, er, lat);
    chk("lh_mis_err", 0, 32'(er), 32'h1);
    txn(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    chk("illegal_err", 0, 32'(er), 32'h1);
    chk("illegal_lat", 0, lat, 1);
    txn(0, 1'b1, 3'b000, 32'h12, 32'h01234567, rd, er, lat);
    chk("sw_mis_err", 0, 32'(er), 32'h1);
    txn(0, 1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat);
    chk("err_no_write", 0, rd, 32'hDEAD7FEF);

    // back-to-back with req_valid held high
    n0 = nresp[0];
    issue(0, 1'b1, 3'b000, 32'h20, 32'h11111111, acc[0]);
    issue(0, 1'b1, 3'b000, 32'h24, 32'h22222222, acc[1]);
    issue(0, 1'b1, 3'b010, 32'h26, 32'h0000BEEF, acc[2]);
    issue(0, 1'b0, 3'b000, 32'h20, 32'h0, acc[3]);
    issue(0, 1'b0, 3'b000, 32'h24, 32'h0, acc[4]);
    issue(0, 1'b0, 3'b101, 32'h27, 32'h0, acc[5]);
    rv[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_resp_count", 0, nresp[0] - n0, 6);
    chk("b2b_spacing_a", 0, acc[1] - acc[0], 4);
    chk("b2b_spacing_b", 0, acc[5] - acc[4], 4);
    txn(0, 1'b0, 3'b000, 32'h24, 32'h0, rd, er, lat);
    chk("b2b_half_store", 0, rd, 32'hBEEF2222);

    // reset during WAIT discards the pending store
    n0 = nresp[0];
    issue(0, 1'b1, 3'b000, 32'h10, 32'h12345678, at);
    rv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_resp", 0, nresp[0] - n0, 0);
    txn(0, 1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat);
    chk("rst_store_dropped", 0, rd, 32'hDEAD7FEF);

    // randomized traffic on words 0..15 with random high address bits
    for (int w = 0; w < 16; w++) txn(0, 1'b1, 3'b000, 32'(w * 4), $urandom, rd, er, lat);
    for (int n = 0; n < 300; n++) begin
      issue(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_F03F, $urandom, at);
      g = $urandom_range(0, 2);
      if (g != 0) begin
        rv[0] = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 24) == 0) begin
        rv[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    rv[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // zero wait states, 16-word RAM with address wrap
    txn(1, 1'b1, 3'b000, 32'h40, 32'hCAFEF00D, rd, er, lat);
    chk("w0_sw_latency", 1, lat, 1);
    txn(1, 1'b0, 3'b000, 32'h00, 32'h0, rd, er, lat);
    chk("w0_alias_rdata", 1, rd, 32'hCAFEF00D);
    chk("w0_lw_latency", 1, lat, 1);
    for (int w = 0; w < 16; w++) txn(1, 1'b1, 3'b000, 32'(w * 4), $urandom, rd, er, lat);
    for (int n = 0; n < 200; n++) begin
      issue(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, at);
      g = $urandom_range(0, 1);
      if (g != 0) begin
        rv[1] = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rv[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
